dbg_step_dump: RTL and testbench
================================

Name: dbg_step_dump

Overview:
- Parametrised UART debug controller between uart_rx, the tx char FIFO and the Pipeline clock-enable.
- Decodes single-byte commands from uart_rx: step, run, halt, dump.
- Gates the pipeline with a one-cycle or continuous step enable.
- Snapshots a flattened probe bus of NUM_WORDS words and streams it, LSB byte first, into the tx FIFO under full-flag back-pressure.

Parameters:
- NUM_WORDS, 2: number of probe words dumped per snapshot (1..64).
- WORD_W, 32: probe word width in bits; must be a multiple of 8.
- CMD_STEP, 8'h41 ("A"): step one pipeline cycle, then dump.
- CMD_RUN, 8'h52 ("R"): free-run the pipeline until halt.
- CMD_HALT, 8'h48 ("H"): stop a run, then dump.
- CMD_DUMP, 8'h44 ("D"): dump without stepping.
- HDR_BYTE, 8'h42 ("B"): header byte written before each dump.
- ERR_BYTE, 8'h3F ("?"): byte written for an unknown command.

Ports:
- clk  in  1  system clock (clockDivider output).
- rst_n  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte from uart_rx.
- rx_data_rdy  in  1  uart_rx ready level; each rising edge marks one new byte.
- halt_req  in  1  external halt request (e.g. breakpoint); honoured only in RUN.
- probe_bus  in  NUM_WORDS*WORD_W  probe words; word i = bits [i*WORD_W +: WORD_W].
- fifo_full  in  1  tx char FIFO full flag.
- fifo_din  out  8  byte to the tx FIFO.
- fifo_wr_en  out  1  tx FIFO write strobe.
- pipe_step  out  1  pipeline clock enable; one clk of pipe_step = one pipeline cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; pipe_step=0, fifo_wr_en=0, fifo_din=0, busy=0; byte index=0; snapshot=0; rdy_q=1, so a level already high at reset release is not taken as a byte.
- Byte detect: new_byte = rx_data_rdy & ~rdy_q; rdy_q registered every clk.
- States: IDLE, STEP, RUN, SNAP, HDR, SEND, ERR.
- IDLE, on new_byte (cycle N), next state by rx_data:
  - CMD_STEP -> STEP
  - CMD_RUN -> RUN
  - CMD_DUMP -> SNAP
  - CMD_HALT -> IDLE (no-op, nothing written)
  - any other byte -> ERR
- STEP: lasts exactly one cycle (N+1); pipe_step=1; then SNAP.
- RUN: pipe_step=1 every cycle. Exit to SNAP on halt_req=1 or new_byte with CMD_HALT; both in the same cycle give a single exit. pipe_step=0 from the exit cycle onward. Other bytes received in RUN are dropped.
- SNAP: one cycle; probe_bus is latched into the shadow register; then HDR. The pipeline is already frozen, so the snapshot is coherent.
- HDR: fifo_din=HDR_BYTE; fifo_wr_en=~fifo_full. Move to SEND on the cycle the write occurs; otherwise hold.
- SEND:
  - fifo_din = shadow byte[idx], byte k of word i at idx = i*(WORD_W/8)+k.
  - fifo_wr_en=~fifo_full; idx increments only when written.
  - After the last byte: idx=0, state -> IDLE.
- ERR: fifo_din=ERR_BYTE; fifo_wr_en=~fifo_full; return to IDLE when written.
- fifo_wr_en is combinational from the registered state and fifo_full. It is never high while fifo_full=1 or in IDLE, STEP, RUN or SNAP.
- Bytes received in STEP, SNAP, HDR, SEND or ERR are dropped (no queueing).
- Minimum latency, command byte to first FIFO write: STEP = 3 cycles after N; DUMP = 2 cycles.
- Dump length = 1 + NUM_WORDS*WORD_W/8 bytes; idx width = clog2 of that length.
- rst_n low mid-dump aborts immediately to reset values; the partial dump is not completed.

Optional Feature:
- Macro DBG_CYCLE_COUNT_EN.
- Defined:
  - A 32-bit counter increments on every clk with pipe_step=1 and wraps 0xFFFFFFFF->0.
  - It is cleared only by rst_n.
  - SNAP also latches the counter; SEND appends its 4 bytes, LSB first, after the probe words. Dump length grows by 4.
- Undefined: no counter logic; dump is header plus probe words only.

Test Plan:
- Step: NUM_WORDS=2, probe_bus={32'hDEADBEEF,32'h00000004}, send 0x41 -> pipe_step high exactly 1 cycle; FIFO receives 42 04 00 00 00 EF BE AD DE; busy then low.
- Back-pressure: same dump with fifo_full forced high for 5 cycles mid-SEND -> fifo_wr_en=0 throughout the stall; byte sequence unchanged, no duplicates or drops.
- Run/halt: send 0x52, wait 100 cycles, send 0x48 -> pipe_step high for a contiguous run, then low; dump follows; with DBG_CYCLE_COUNT_EN the last 4 bytes equal the pipe_step cycle count.
- Halt sources: assert halt_req in the same cycle as a CMD_HALT byte -> exactly one dump; halt_req in IDLE -> no action.
- Errors/drops: send 0x5A -> single 3F written; send 0x41 then 0x41 during SEND -> the second is ignored and only one dump appears.
- Reset: deassert rst_n at SEND idx=3 -> next cycle all outputs 0 and state IDLE; rx_data_rdy held high across reset release -> no command decoded.

Source files
------------

// File: rtl/dbg_step_dump.sv
// ---------------------------------------------------------------------------
// dbg_step_dump
//
// UART debug controller sitting between uart_rx, the tx character FIFO and
// the pipeline clock enable. Single-byte commands received from uart_rx:
//   CMD_STEP : advance the pipeline one cycle, then dump the probes
//   CMD_RUN  : free-run the pipeline until a halt
//   CMD_HALT : stop a run, then dump (no-op when idle)
//   CMD_DUMP : dump the probes without stepping
// Unknown bytes produce a single ERR_BYTE. A dump is HDR_BYTE followed by
// the shadowed probe words, LSB byte of word 0 first.
//
// Optional feature, macro DBG_CYCLE_COUNT_EN: a 32-bit free-running count of
// pipe_step cycles is snapshotted with the probes and appended (LSB first)
// to every dump.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   rx_data      received byte from uart_rx
//   rx_data_rdy  uart_rx ready level; a rising edge marks one new byte
//   halt_req     external halt request, honoured only while running
//   probe_bus    NUM_WORDS probe words, word i at [i*WORD_W +: WORD_W]
//   fifo_full    tx FIFO full flag (back-pressure)
//   fifo_din     byte presented to the tx FIFO
//   fifo_wr_en   tx FIFO write strobe
//   pipe_step    pipeline clock enable
//   busy         high whenever the controller is not idle
// ---------------------------------------------------------------------------
module dbg_step_dump #(
    parameter int           NUM_WORDS = 2,
    parameter int           WORD_W    = 32,
    parameter logic [7:0]   CMD_STEP  = 8'h41,
    parameter logic [7:0]   CMD_RUN   = 8'h52,
    parameter logic [7:0]   CMD_HALT  = 8'h48,
    parameter logic [7:0]   CMD_DUMP  = 8'h44,
    parameter logic [7:0]   HDR_BYTE  = 8'h42,
    parameter logic [7:0]   ERR_BYTE  = 8'h3F
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_data_rdy,
    input  logic                        halt_req,
    input  logic [NUM_WORDS*WORD_W-1:0] probe_bus,
    input  logic                        fifo_full,
    output logic [7:0]                  fifo_din,
    output logic                        fifo_wr_en,
    output logic                        pipe_step,
    output logic                        busy
);

    localparam int PROBE_BYTES = NUM_WORDS * (WORD_W / 8);
`ifdef DBG_CYCLE_COUNT_EN
    localparam int CNT_BYTES   = 4;
`else
    localparam int CNT_BYTES   = 0;
`endif
    // Bytes streamed after the header; full dump is one longer.
    localparam int SEND_LEN    = PROBE_BYTES + CNT_BYTES;
    localparam int DUMP_LEN    = 1 + SEND_LEN;
    localparam int IDX_W       = $clog2(DUMP_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEND_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_RUN,
        ST_SNAP,
        ST_HDR,
        ST_SEND,
        ST_ERR
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               rdy_q_reg;
    logic               new_byte;
    logic               run_exit;
    logic [7:0]         send_byte;

    // Live bytes to capture and their shadow copy, in stream order.
    logic [7:0]         snap_bytes [SEND_LEN];
    logic [7:0]         shadow_reg [SEND_LEN];

    // ------------------------------------------------------------------
    // Byte detect. rdy_q resets high so a ready level that is already
    // asserted when reset releases is not mistaken for a fresh byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q_reg <= 1'b1;
        end else begin
            rdy_q_reg <= rx_data_rdy;
        end
    end

    assign new_byte = rx_data_rdy & ~rdy_q_reg;

    // A halt byte and halt_req together still produce a single exit.
    assign run_exit = halt_req | (new_byte & (rx_data == CMD_HALT));

    // ------------------------------------------------------------------
    // Snapshot sources: probe bytes in flat order (byte k of word i sits
    // at i*WORD_W + 8k, i.e. flat byte i*(WORD_W/8)+k), then the counter.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < PROBE_BYTES; gi++) begin : g_probe_bytes
            assign snap_bytes[gi] = probe_bus[gi*8 +: 8];
        end
    endgenerate

`ifdef DBG_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt_reg;

    // Counts pipeline cycles; wraps naturally and is cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_reg <= 32'd0;
        end else if (pipe_step) begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_bytes
            assign snap_bytes[PROBE_BYTES + gi] = cycle_cnt_reg[gi*8 +: 8];
        end
    endgenerate
`endif

    // Shadow register: captured in SNAP while the pipeline is frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SEND_LEN; i++) begin
                shadow_reg[i] <= 8'h00;
            end
        end else if (state_reg == ST_SNAP) begin
            for (int i = 0; i < SEND_LEN; i++) begin
                shadow_reg[i] <= snap_bytes[i];
            end
        end
    end

    // Byte selected by the stream index.
    always_comb begin
        send_byte = 8'h00;
        for (int i = 0; i < SEND_LEN; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                send_byte = shadow_reg[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. All outputs derive from the registered
    // state plus fifo_full / the run exit condition, so writes never
    // occur while the FIFO is full.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        fifo_din   = 8'h00;
        fifo_wr_en = 1'b0;
        pipe_step  = 1'b0;
        busy       = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (new_byte) begin
                    if (rx_data == CMD_STEP) begin
                        state_next = ST_STEP;
                    end else if (rx_data == CMD_RUN) begin
                        state_next = ST_RUN;
                    end else if (rx_data == CMD_DUMP) begin
                        state_next = ST_SNAP;
                    end else if (rx_data == CMD_HALT) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end

            ST_STEP: begin
                pipe_step  = 1'b1;
                state_next = ST_SNAP;
            end

            ST_RUN: begin
                // The pipeline is frozen from the exit cycle itself.
                pipe_step = ~run_exit;
                if (run_exit) begin
                    state_next = ST_SNAP;
                end
            end

            ST_SNAP: begin
                state_next = ST_HDR;
            end

            ST_HDR: begin
                fifo_din   = HDR_BYTE;
                fifo_wr_en = ~fifo_full;
                if (!fifo_full) begin
                    state_next = ST_SEND;
                end
            end

            ST_SEND: begin
                fifo_din   = send_byte;
                fifo_wr_en = ~fifo_full;
                if (!fifo_full) begin
                    if (idx_reg == IDX_LAST) begin
                        idx_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end

            ST_ERR: begin
                fifo_din   = ERR_BYTE;
                fifo_wr_en = ~fifo_full;
                if (!fifo_full) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dbg_step_dump.sv
// ---------------------------------------------------------------------------
// tb_dbg_step_dump
//
// Directed bench for dbg_step_dump (NUM_WORDS=2, WORD_W=32). A negedge
// monitor captures every FIFO write and counts pipe_step cycles; each test
// compares those against hand-derived byte streams, cycle counts and
// latencies. Counter bytes are expected only when DBG_CYCLE_COUNT_EN is set.
// ---------------------------------------------------------------------------
module tb_dbg_step_dump;

    localparam logic [63:0] PROBE_A = {32'hDEADBEEF, 32'h00000004};
    localparam logic [63:0] PROBE_B = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_data_rdy;
    logic        halt_req;
    logic [63:0] probe_bus;
    logic        fifo_full;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        pipe_step;
    logic        busy;

    dbg_step_dump #(
        .NUM_WORDS (2),
        .WORD_W    (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .halt_req    (halt_req),
        .probe_bus   (probe_bus),
        .fifo_full   (fifo_full),
        .fifo_din    (fifo_din),
        .fifo_wr_en  (fifo_wr_en),
        .pipe_step   (pipe_step),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state
    logic [7:0] wr_q[$];
    int         cyc = 0;
    int         cmd_cyc = 0;
    int         first_wr_cyc = -1;
    int         step_cnt = 0;
    int         step_rises = 0;
    int         bp_viol = 0;
    logic       step_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            if (wr_q.size() == 0) first_wr_cyc = cyc;
            wr_q.push_back(fifo_din);
            if (fifo_full) bp_viol++;
        end
        if (pipe_step) step_cnt++;
        if (pipe_step && !step_prev) step_rises++;
        step_prev = pipe_step;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        step_cnt     = 0;
        step_rises   = 0;
        bp_viol      = 0;
        first_wr_cyc = -1;
    endtask

    // Present one byte: ready rises for one clk; new_byte is seen in the
    // cycle starting at the first posedge (recorded as cmd_cyc).
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data     = b;
        rx_data_rdy = 1'b1;
        cmd_cyc     = cyc;
        @(posedge clk);
        #1;
        rx_data_rdy = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check({tag, "_timeout"}, 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_dump(input string tag, input logic [63:0] probe, input logic [31:0] cnt);
        logic [7:0] exp_q[$];
        exp_q.push_back(8'h42);
        for (int i = 0; i < 8; i++) exp_q.push_back(probe[i*8 +: 8]);
`ifdef DBG_CYCLE_COUNT_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(cnt[i*8 +: 8]);
`endif
        check({tag, "_len"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_q.size()) check($sformatf("%s_b%0d", tag, i), {24'd0, wr_q[i]}, {24'd0, exp_q[i]});
        end
        $display("dump %s: %0d bytes observed, model count %0d", tag, wr_q.size(), cnt);
        wr_q.delete();
    endtask

    int cyc_model = 0;

    initial begin
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_data_rdy = 1'b0;
        halt_req    = 1'b0;
        probe_bus   = PROBE_A;
        fifo_full   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_din",   fifo_din,   0);
        check("rst_step",  pipe_step,  0);
        check("rst_busy",  busy,       0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        clear_mon();

        // Step: one pipeline cycle, first write 3 cycles after the command
        send_byte(8'h41);
        wait_idle("step");
        cyc_model += 1;
        check("step_cnt",   step_cnt, 1);
        check("step_rises", step_rises, 1);
        check("step_lat",   first_wr_cyc - cmd_cyc, 3);
        check("step_busy",  busy, 0);
        check_dump("step", PROBE_A, cyc_model);
        clear_mon();

        // Back-pressure: FIFO full for 5 cycles starting at SEND idx 2
        send_byte(8'h41);
        repeat (5) @(posedge clk);
        #1 fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_wr_en", fifo_wr_en, 0);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        wait_idle("bp");
        cyc_model += 1;
        check("bp_viol", bp_viol, 0);
        check_dump("bp", PROBE_A, cyc_model);
        clear_mon();

        // Run for 101 enabled cycles, then halt byte
        send_byte(8'h52);
        repeat (100) @(posedge clk);
        send_byte(8'h48);
        wait_idle("run");
        cyc_model += 101;
        check("run_cnt",   step_cnt, 101);
        check("run_rises", step_rises, 1);
        check_dump("run", PROBE_A, cyc_model);
        clear_mon();

        // Halt byte and halt_req in the same cycle: a single dump
        send_byte(8'h52);
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1;
        rx_data     = 8'h48;
        rx_data_rdy = 1'b1;
        halt_req    = 1'b1;
        @(posedge clk);
        #1;
        rx_data_rdy = 1'b0;
        halt_req    = 1'b0;
        wait_idle("dualhalt");
        cyc_model += 4;
        check("dualhalt_cnt", step_cnt, 4);
        check_dump("dualhalt", PROBE_A, cyc_model);
        clear_mon();

        // halt_req and CMD_HALT while idle do nothing
        @(posedge clk);
        #1 halt_req = 1'b1;
        repeat (4) @(posedge clk);
        #1 halt_req = 1'b0;
        send_byte(8'h48);
        repeat (4) @(negedge clk);
        check("idlehalt_busy",   busy, 0);
        check("idlehalt_writes", wr_q.size(), 0);
        check("idlehalt_step",   step_cnt, 0);
        $display("idle halt: %0d writes", wr_q.size());
        clear_mon();

        // Unknown command: single error byte
        send_byte(8'h5A);
        wait_idle("err");
        check("err_len", wr_q.size(), 1);
        if (wr_q.size() > 0) check("err_byte", {24'd0, wr_q[0]}, 32'h3F);
        check("err_step", step_cnt, 0);
        $display("error cmd: %0d writes", wr_q.size());
        clear_mon();

        // Dump without stepping, different probe pattern, 2-cycle latency
        probe_bus = PROBE_B;
        send_byte(8'h44);
        wait_idle("dump");
        check("dump_lat",  first_wr_cyc - cmd_cyc, 2);
        check("dump_step", step_cnt, 0);
        check_dump("dump", PROBE_B, cyc_model);
        clear_mon();
        probe_bus = PROBE_A;

        // Second step byte arriving during SEND is dropped
        send_byte(8'h41);
        repeat (3) @(posedge clk);
        send_byte(8'h41);
        wait_idle("drop");
        repeat (5) @(negedge clk);
        cyc_model += 1;
        check("drop_step", step_cnt, 1);
        check_dump("drop", PROBE_A, cyc_model);
        clear_mon();

        // Reset mid-dump at SEND idx 3, ready held high through release
        send_byte(8'h41);
        repeat (6) @(posedge clk);
        #1;
        rst_n       = 1'b0;
        rx_data     = 8'h41;
        rx_data_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_wr_en", fifo_wr_en, 0);
        check("abort_din",   fifo_din,   0);
        check("abort_step",  pipe_step,  0);
        check("abort_busy",  busy,       0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        repeat (5) @(negedge clk);
        check("relhigh_busy",   busy, 0);
        check("relhigh_writes", wr_q.size(), 0);
        check("relhigh_step",   step_cnt, 0);
        $display("reset abort: %0d writes after release", wr_q.size());
        @(posedge clk);
        #1 rx_data_rdy = 1'b0;
        cyc_model = 0;
        clear_mon();

        // Controller works again after reset; counter restarted
        send_byte(8'h41);
        wait_idle("post");
        cyc_model += 1;
        check("post_step", step_cnt, 1);
        check_dump("post", PROBE_A, cyc_model);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
